// File: rtl/vga_stream_timing.sv
// vga_stream_timing: VGA timing generator with a valid/ready pixel-stream sink.
// Ports:
//   pixel_clk, pixel_rst   clock and asynchronous active-high reset
//   enable                 allow stream consumption (timing always runs)
//   pix_data/valid/sof     stream head; sof marks pixel (0,0) of a frame
//   pix_ready              head consumed when pix_valid && pix_ready
//   HS, VS, BLANK, RGB     registered video outputs (BLANK=1 means active video)
//   frame_start            pulse with the first active pixel of a frame
//   underflow, sync_err    sticky error flags, cleared by err_clr
module vga_stream_timing #(
    parameter int HDISP   = 800,
    parameter int VDISP   = 480,
    parameter int HFP     = 40,
    parameter int HPULSE  = 48,
    parameter int HBP     = 40,
    parameter int VFP     = 13,
    parameter int VPULSE  = 3,
    parameter int VBP     = 29,
    parameter int HS_POL  = 0,
    parameter int VS_POL  = 0,
    parameter int PIX_FMT = 0,
    parameter int DATA_W  = 32
) (
    input  logic              pixel_clk,
    input  logic              pixel_rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic              pix_ready,
    output logic              HS,
    output logic              VS,
    output logic              BLANK,
    output logic [23:0]       RGB,
    output logic              frame_start,
    output logic              underflow,
    output logic              sync_err,
    input  logic              err_clr
);
    localparam int XLEN = HDISP + HFP + HPULSE + HBP;
    localparam int YLEN = VDISP + VFP + VPULSE + VBP;
    localparam int XW = $clog2(XLEN);
    localparam int YW = $clog2(YLEN);
    localparam logic HS_ON = HS_POL != 0;
    localparam logic VS_ON = VS_POL != 0;
    typedef enum logic {WAIT_SOF, RUN} state_t;
    state_t state, state_nx;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic x_end, y_end, active, origin, h_pulse, v_pulse;
    logic set_uf, set_se, disp;
    logic [DATA_W+23:0] dw;
    logic [23:0] pix_rgb;
    logic unused_dw;
    assign x_end   = 32'(px) == XLEN - 1;
    assign y_end   = 32'(py) == YLEN - 1;
    assign active  = 32'(px) < HDISP && 32'(py) < VDISP;
    assign origin  = px == '0 && py == '0;
    assign h_pulse = 32'(px) >= HDISP + HFP && 32'(px) < HDISP + HFP + HPULSE;
    assign v_pulse = 32'(py) >= VDISP + VFP && 32'(py) < VDISP + VFP + VPULSE;
    // zero-pad so both unpack formats can be sliced for any legal DATA_W
    assign dw = (DATA_W + 24)'(pix_data);
    assign unused_dw = ^dw[DATA_W+23:24];
    assign pix_rgb = PIX_FMT != 0 ? {dw[15:11], dw[15:13], dw[10:5], dw[10:9], dw[4:0], dw[4:2]}
                                  : dw[23:0];
    assign disp = state == RUN && pix_ready && pix_valid;
    always_ff @(posedge pixel_clk or posedge pixel_rst)
        if (pixel_rst) begin
            px <= '0;
            py <= '0;
        end else begin
            px <= x_end ? '0 : px + XW'(1);
            if (x_end) py <= y_end ? '0 : py + YW'(1);
        end
    always_ff @(posedge pixel_clk or posedge pixel_rst)
        if (pixel_rst) state <= WAIT_SOF;
        else state <= state_nx;
    // WAIT_SOF drops non-SOF words and holds an SOF head until the frame wraps;
    // RUN consumes only on active pixels and refuses an SOF that arrives early.
    always_comb begin
        state_nx  = state;
        pix_ready = 1'b0;
        set_uf    = 1'b0;
        set_se    = 1'b0;
        if (state == WAIT_SOF) begin
            pix_ready = enable && pix_valid && !pix_sof;
            if (enable && pix_valid && pix_sof && x_end && y_end) state_nx = RUN;
        end else begin
            pix_ready = enable && active && !(pix_sof && !origin);
            set_uf    = enable && active && !pix_valid;
            set_se    = enable && active && pix_valid && (pix_sof != origin);
            if (!enable || set_uf || set_se) state_nx = WAIT_SOF;
        end
        if (pixel_rst) pix_ready = 1'b0;
    end
    always_ff @(posedge pixel_clk or posedge pixel_rst)
        if (pixel_rst) begin
            HS          <= !HS_ON;
            VS          <= !VS_ON;
            BLANK       <= 1'b0;
            RGB         <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            HS          <= h_pulse ? HS_ON : !HS_ON;
            VS          <= v_pulse ? VS_ON : !VS_ON;
            BLANK       <= active;
            RGB         <= disp ? pix_rgb : '0;
            frame_start <= origin;
            underflow   <= set_uf || (underflow && !err_clr);
            sync_err    <= set_se || (sync_err && !err_clr);
        end
endmodule

// File: doc/vga_stream_timing.md
Name: vga_stream_timing

Overview:
Parametrised VGA timing generator and pixel-stream sink for the pixel_clk domain. It generates HS/VS/BLANK from fully parametrised porch and pulse widths with selectable sync polarity. It pulls pixels from a valid/ready stream, normally the read side of the frame-buffer async FIFO, and unpacks them in RGB888 or RGB565 format. Frame alignment uses a start-of-frame marker, with underflow and sync-error detection and automatic resynchronisation.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
HFP, 40, horizontal front porch (pixels)
HPULSE, 48, HS pulse width (pixels)
HBP, 40, horizontal back porch (pixels)
VFP, 13, vertical front porch (lines)
VPULSE, 3, VS pulse width (lines)
VBP, 29, vertical back porch (lines)
HS_POL, 0, 0 = HS active-low, 1 = active-high
VS_POL, 0, 0 = VS active-low, 1 = active-high
PIX_FMT, 0, 0 = RGB888 in data[23:0]; 1 = RGB565 in data[15:0]
DATA_W, 32, stream word width (≥24 if PIX_FMT=0, ≥16 if PIX_FMT=1)

Ports:
pixel_clk  in  1  pixel clock
pixel_rst  in  1  asynchronous, active-high reset
enable  in  1  stream consumption enable; timing always runs
pix_data  in  DATA_W  stream pixel word
pix_valid  in  1  pix_data valid
pix_sof  in  1  current word is pixel (0,0) of a frame
pix_ready  out  1  word consumed when pix_valid && pix_ready
HS  out  1  horizontal sync, polarity per HS_POL
VS  out  1  vertical sync, polarity per VS_POL
BLANK  out  1  1 = active video (same sense as video_if.BLANK)
RGB  out  24  pixel {R,G,B}, 0 outside active video
frame_start  out  1  1-cycle pulse aligned with first active pixel output
underflow  out  1  sticky: active pixel requested with !pix_valid
sync_err  out  1  sticky: SOF at wrong position or missing at (0,0)
err_clr  in  1  synchronous clear of underflow and sync_err

Behaviour:
- XLEN = HDISP+HFP+HPULSE+HBP, YLEN = VDISP+VFP+VPULSE+VBP. px width $clog2(XLEN), py width $clog2(YLEN).
- px increments each cycle. At XLEN-1, px wraps to 0 and py increments. py wraps to 0 after YLEN-1. Reset: px=py=0.
- active = (px<HDISP && py<VDISP). Sync pulse when HDISP+HFP ≤ px < HDISP+HFP+HPULSE (same form for py).
- All video outputs are registered, with 1-cycle latency from counters. BLANK = active. HS/VS drive the active level during the pulse, otherwise the inactive level. frame_start = (px==0 && py==0). RGB = unpacked consumed word if active and a word was consumed, else 0.
- RGB565 unpack: R = {d[15:11],d[15:13]}, G = {d[10:5],d[10:9]}, B = {d[4:0],d[4:2]}.
- Reset values: HS = !HS_POL, VS = !VS_POL, BLANK=0, RGB=0, frame_start=0, underflow=0, sync_err=0, state=WAIT_SOF.
- pix_ready is combinational from state, counters and stream head. It is 0 while pixel_rst is asserted.
- FSM WAIT_SOF (entered at reset, from any state when enable=0, or on error):
  - pix_ready = enable && pix_valid && !pix_sof, which drops stale words.
  - Head with pix_sof is held, not consumed.
  - Go to RUN when head holds SOF and enable && px==XLEN-1 && py==YLEN-1.
  - Active pixels output RGB 0.
- FSM RUN: pix_ready = active && !(pix_sof && !(px==0 && py==0)).
  - Active && !pix_valid: RGB 0 for that pixel, underflow set, go to WAIT_SOF.
  - Head has pix_sof at an active position ≠(0,0): word not consumed, sync_err set, go to WAIT_SOF.
  - Word consumed at (0,0) without pix_sof: sync_err set, word displayed, go to WAIT_SOF.
- Error flags: underflow and sync_err are sticky. err_clr clears them next cycle. A set event on the same cycle as err_clr wins (flag stays 1).
- enable deassert mid-frame: immediate WAIT_SOF, remaining active pixels black, timing unaffected.
- Reset mid-frame: all outputs and counters return to reset values asynchronously. Stream words are not consumed during reset.

Test Plan:
- HDISP=4,VDISP=2,HFP=1,HPULSE=2,HBP=1,VFP=1,VPULSE=1,VBP=1, stream always valid -> XLEN=8, YLEN=5. HS low exactly for px 5–6 (seen 1 cycle later). VS low on line 3. BLANK high 4 cycles per line on lines 0–1. frame_start every 40 cycles.
- Stream delivers 3 words without SOF, then SOF frame with words 0x00112233.. -> first 3 words dropped. First displayed RGB=0x112233 coincident with frame_start, one frame after SOF arrives.
- PIX_FMT=1, words 0xF800, 0x07E0, 0x001F, 0xFFFF -> RGB 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF.
- In RUN, drop pix_valid for pixel (2,1) -> RGB 0 there. underflow=1, stays 1 until err_clr, resync at next frame with SOF.
- Assert pix_sof on word for pixel (1,0) -> sync_err=1, word not consumed, displayed from (0,0) next frame. err_clr with simultaneous new error -> flag stays 1.
- HS_POL=1, VS_POL=1 -> reset HS=VS=0, pulses active-high. Assert pixel_rst mid-line -> all outputs to reset values same cycle, pix_ready=0.
